// File: rtl/execute_stage_pkg.sv
// ---------------------------------------------------------------------------
// execute_stage_pkg
// Shared definitions for the EX stage: ALUOp codes, R-type funct codes,
// multiply FSM state encoding, the EX/MEM register layout and a small
// decode helper.
// ---------------------------------------------------------------------------
package execute_stage_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // EX/MEM pipeline register contents. An all-zero value is a bubble.
    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic        zero;
        logic [31:0] outpc;
        logic [31:0] alu_result;
        logic [31:0] data2;
        logic [4:0]  mux_out;
    } exmem_t;

    function automatic logic is_mult_funct(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU);
    endfunction

endpackage

// File: rtl/execute_stage_iter_multiplier.sv
// ---------------------------------------------------------------------------
// iter_multiplier
// Iterative shift-add 32x32 -> 64 multiplier retiring MUL_STEP multiplier
// bits per cycle, N = 32/MUL_STEP cycles per operation. Signed operations
// multiply magnitudes and negate the 64-bit product if operand signs differ.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start_i         load operands and begin (ignored while busy)
//   abort_i         drop the operation in flight
//   signed_op_i     1 = MULT (signed), 0 = MULTU
//   a_i, b_i        operands
//   busy_o          iteration in progress
//   done_o          the final iteration completes at this clock edge
//   hi_o, lo_o      product, valid the cycle after done_o
// ---------------------------------------------------------------------------
module iter_multiplier #(
    parameter int MUL_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        signed_op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    import execute_stage_pkg::*;

    localparam int N  = 32 / MUL_STEP;
    localparam int CW = $clog2(N);

    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   mcand_q;
    logic [63:0]   prod_q;   // {partial sum, remaining multiplier bits}
    logic [63:0]   prod_d;
    logic          neg_q;
    logic [32:0]   sum;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic [63:0]   result;

    assign a_mag = (signed_op_i && a_i[31]) ? (~a_i + 32'd1) : a_i;
    assign b_mag = (signed_op_i && b_i[31]) ? (~b_i + 32'd1) : b_i;

    // MUL_STEP shift-add steps per cycle; the 33-bit sum keeps the carry,
    // which shifts into the top of the partial product.
    always_comb begin
        prod_d = prod_q;
        sum    = '0;
        for (int s = 0; s < MUL_STEP; s++) begin
            sum    = {1'b0, prod_d[63:32]} + (prod_d[0] ? {1'b0, mcand_q} : 33'd0);
            prod_d = {sum, prod_d[31:1]};
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CW'(N - 1));
    assign result = neg_q ? (~prod_q + 64'd1) : prod_q;
    assign hi_o   = result[63:32];
    assign lo_o   = result[31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i && !busy_q) begin
            mcand_q <= a_mag;
            prod_q  <= {32'd0, b_mag};
            neg_q   <= signed_op_i & (a_i[31] ^ b_i[31]);
            busy_q  <= 1'b1;
            cnt_q   <= '0;
        end else if (busy_q) begin
            prod_q <= prod_d;
            if (done_o) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
// EX pipeline stage: ALU, branch-target adder, destination register select,
// iterative MULT/MULTU with HI/LO, and the EX/MEM register.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   flush_in                   load a bubble into EX/MEM, abort any multiply
//   *_in, RegDst, ALUSrc       ID/EX control bits
//   ALUOp                      00 add, 01 sub, 10 R-type funct, 11 slt
//   pc_plus4, read_data1/2     PC+4, rs/rt operands
//   sign_ext_imm               immediate; funct=[5:0], shamt=[10:6]
//   rt, rd                     destination candidates
//   stall_out                  hold PC, IF/ID, ID/EX (combinational)
//   RegWrite..ZeroFlag, outpc, alu_result, data2, mux_out   EX/MEM register
//   dbg_state_o                multiply FSM state
// Handshake: an ID/EX instruction is consumed at every rising edge where
// stall_out is 0; while stall_out is 1 upstream must hold ID/EX stable and
// EX/MEM receives bubbles.
// ---------------------------------------------------------------------------
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int MUL_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_in,
    input  logic        RegWrite_in,
    input  logic        MemToReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        Branch_in,
    input  logic        RegDst,
    input  logic        ALUSrc,
    input  logic [1:0]  ALUOp,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic [31:0] sign_ext_imm,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    output logic        stall_out,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic        ZeroFlag,
    output logic [31:0] outpc,
    output logic [31:0] alu_result,
    output logic [31:0] data2,
    output logic [4:0]  mux_out,
    output logic [1:0]  dbg_state_o
);

    mul_state_e  state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    exmem_t      exmem_q, exmem_d, live;

    logic [31:0] b_op, target, alu_res;
    logic [4:0]  dest, shamt;
    logic [5:0]  funct;
    logic        rw_ok, is_mult, mul_start;
    logic        mul_busy, mul_done;
    logic [31:0] mul_hi, mul_lo;

    assign funct   = sign_ext_imm[5:0];
    assign shamt   = sign_ext_imm[10:6];
    assign b_op    = ALUSrc ? sign_ext_imm : read_data2;
    assign target  = pc_plus4 + (sign_ext_imm << 2);
    assign dest    = RegDst ? rd : rt;
    assign is_mult = (ALUOp == ALUOP_RTYPE) && is_mult_funct(funct);

    // Flush wins over everything; reset also drops the stall request so the
    // front end is not frozen while this stage is held in reset.
    assign stall_out = rst_n && !flush_in &&
                       (((state_q == ST_IDLE) && is_mult) || (state_q == ST_BUSY));
    assign mul_start = (state_q == ST_IDLE) && is_mult && !flush_in;

    iter_multiplier #(.MUL_STEP(MUL_STEP)) u_mul (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (mul_start),
        .abort_i     (flush_in),
        .signed_op_i (funct == F_MULT),
        .a_i         (read_data1),
        .b_i         (b_op),
        .busy_o      (mul_busy),
        .done_o      (mul_done),
        .hi_o        (mul_hi),
        .lo_o        (mul_lo)
    );

    // ALU. Multiplies and unknown functs produce 0 and never write a register.
    always_comb begin
        alu_res = '0;
        rw_ok   = 1'b1;
        case (ALUOp)
            ALUOP_ADD: alu_res = read_data1 + b_op;
            ALUOP_SUB: alu_res = read_data1 - b_op;
            ALUOP_SLT: alu_res = {31'd0, $signed(read_data1) < $signed(b_op)};
            ALUOP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: alu_res = read_data1 + b_op;
                    F_SUB, F_SUBU: alu_res = read_data1 - b_op;
                    F_AND:   alu_res = read_data1 & b_op;
                    F_OR:    alu_res = read_data1 | b_op;
                    F_XOR:   alu_res = read_data1 ^ b_op;
                    F_NOR:   alu_res = ~(read_data1 | b_op);
                    F_SLT:   alu_res = {31'd0, $signed(read_data1) < $signed(b_op)};
                    F_SLTU:  alu_res = {31'd0, read_data1 < b_op};
                    F_SLL:   alu_res = b_op << shamt;
                    F_SRL:   alu_res = b_op >> shamt;
                    F_SRA:   alu_res = 32'($signed(b_op) >>> shamt);
                    F_MFHI:  alu_res = hi_q;
                    F_MFLO:  alu_res = lo_q;
                    F_MULT, F_MULTU: rw_ok = 1'b0;
                    default: rw_ok = 1'b0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        live.regwrite   = RegWrite_in & rw_ok;
        live.memtoreg   = MemToReg_in;
        live.memread    = MemRead_in;
        live.memwrite   = MemWrite_in;
        live.branch     = Branch_in;
        live.zero       = (alu_res == 32'd0);
        live.outpc      = target;
        live.alu_result = alu_res;
        live.data2      = read_data2;
        live.mux_out    = dest;
    end

    // Multiply FSM and EX/MEM next state. Default is a bubble.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        exmem_d = '0;
        if (flush_in) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_mult) state_d = ST_BUSY;
                    else         exmem_d = live;
                end
                ST_BUSY: begin
                    // The !mul_busy arm is defensive recovery only.
                    if (!mul_busy)     state_d = ST_IDLE;
                    else if (mul_done) state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    hi_d    = mul_hi;
                    lo_d    = mul_lo;
                    exmem_d = live;   // multiply retires, regwrite already 0
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            exmem_q <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            exmem_q <= exmem_d;
        end
    end

    assign RegWrite    = exmem_q.regwrite;
    assign MemToReg    = exmem_q.memtoreg;
    assign MemRead     = exmem_q.memread;
    assign MemWrite    = exmem_q.memwrite;
    assign Branch      = exmem_q.branch;
    assign ZeroFlag    = exmem_q.zero;
    assign outpc       = exmem_q.outpc;
    assign alu_result  = exmem_q.alu_result;
    assign data2       = exmem_q.data2;
    assign mux_out     = exmem_q.mux_out;
    assign dbg_state_o = state_q;

endmodule
